fir_systolic_loadable: RTL

- Parametrised N-tap transposed-form FIR filter; one input sample per i_ce, any i_ce duty cycle.
- Coefficients are loaded at run time through a serial shift port, not fixed at build time.
- Output stage applies round-half-up, arithmetic right shift and saturation, and flags overflow.
- Sits between the sample-rate source (ADC/decimator) and downstream DSP in the filtering chain.

---
 rtl/fir_systolic_loadable_pkg.sv | 59 +++++
 rtl/fir_systolic_loadable_mac.sv | 47 ++++
 rtl/fir_systolic_loadable.sv | 94 +++++++++
 3 files changed

// File: rtl/fir_systolic_loadable_pkg.sv
// Shared definitions for the loadable FIR filter family: accumulator width
// derivation and the round/saturate step used on filter outputs.
package fir_systolic_loadable_pkg;

    localparam int RS_W = 64;
    localparam logic signed [RS_W-1:0] RS_ONE = 64'sd1;

    // Rounded and clamped value plus a flag telling whether the clamp engaged.
    typedef struct packed {
        logic signed [RS_W-1:0] value;
        logic                   clamped;
    } rs_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Full-precision accumulator width: no internal wrap for any tap count.
    function automatic int acc_width(input int iw, input int tw, input int ntaps);
        return iw + tw + clog2(ntaps);
    endfunction

    // Round half toward +inf, arithmetic shift right, clamp to an ow-bit
    // signed range. shift == 0 leaves the value unrounded. Accumulators up
    // to RS_W bits wide are supported.
    function automatic rs_t round_sat(input logic signed [RS_W-1:0] v,
                                      input int shift,
                                      input int ow);
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        rs_t o;
        r = v;
        if (shift > 0) begin
            r = (v + (RS_ONE <<< (shift - 1))) >>> shift;
        end
        hi = (RS_ONE <<< (ow - 1)) - RS_ONE;
        lo = -(RS_ONE <<< (ow - 1));
        o.value   = r;
        o.clamped = 1'b0;
        if (r > hi) begin
            o.value   = hi;
            o.clamped = 1'b1;
        end else if (r < lo) begin
            o.value   = lo;
            o.clamped = 1'b1;
        end
        return o;
    endfunction

endpackage

// File: rtl/fir_systolic_loadable_mac.sv
// One tap of the transposed-form FIR: holds its coefficient (part of the
// serial coefficient shift chain) and one stage of the accumulator chain.
module fir_mac_cell
    import fir_systolic_loadable_pkg::*;
#(
    parameter int IW = 12,
    parameter int TW = 12,
    parameter int AW = 28
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 tap_wr,
    input  logic signed [TW-1:0] tap_in,
    output logic signed [TW-1:0] tap_out,
    input  logic                 ce,
    input  logic signed [IW-1:0] sample,
    input  logic signed [AW-1:0] acc_in,
    output logic signed [AW-1:0] acc_out
);

    localparam int PW = IW + TW;

    logic signed [TW-1:0] h;
    logic signed [PW-1:0] prod;

    // Both operands sign-extended to the full product width before multiplying.
    assign prod    = $signed({{TW{sample[IW-1]}}, sample}) * $signed({{IW{h[TW-1]}}, h});
    assign tap_out = h;

    // Coefficient shift register; deliberately outside reset so a reset of
    // the datapath keeps the loaded filter.
    always_ff @(posedge i_clk) begin
        if (tap_wr) begin
            h <= tap_in;
        end
    end

    // Accumulator stage: add this tap's product to the partial sum from above.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_out <= '0;
        end else if (ce) begin
            acc_out <= acc_in + AW'(prod);
        end
    end

endmodule

// File: rtl/fir_systolic_loadable.sv
// Run-time loadable N-tap transposed-form FIR with rounded, saturated output.
// NTAPS must be at least 2.
module fir_systolic_loadable
    import fir_systolic_loadable_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int IW    = 12,
    parameter int TW    = 12,
    parameter int OW    = 16,
    parameter int SHIFT = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tap_wr,
    input  logic signed [TW-1:0] i_tap,
    input  logic                 i_ce,
    input  logic signed [IW-1:0] i_sample,
    output logic                 o_ce,
    output logic signed [OW-1:0] o_result,
    output logic                 o_overflow
);

    localparam int AW = acc_width(IW, TW, NTAPS);

    logic signed [TW-1:0] tap_chain [NTAPS];
    logic signed [AW-1:0] acc_chain [NTAPS];
    logic                 ce_d;
    rs_t                  rs;
    logic                 unused_rs_hi;
    logic                 unused_tap0;

    // Cell k takes its coefficient from cell k+1 and its partial sum from
    // cell k+1; the last cell is fed by the tap port and a zero sum.
    for (genvar k = 0; k < NTAPS; k++) begin : g_cell
        if (k == NTAPS - 1) begin : g_last
            fir_mac_cell #(.IW(IW), .TW(TW), .AW(AW)) u_cell (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .tap_wr  (i_tap_wr),
                .tap_in  (i_tap),
                .tap_out (tap_chain[k]),
                .ce      (i_ce),
                .sample  (i_sample),
                .acc_in  ('0),
                .acc_out (acc_chain[k])
            );
        end else begin : g_mid
            fir_mac_cell #(.IW(IW), .TW(TW), .AW(AW)) u_cell (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .tap_wr  (i_tap_wr),
                .tap_in  (tap_chain[k+1]),
                .tap_out (tap_chain[k]),
                .ce      (i_ce),
                .sample  (i_sample),
                .acc_in  (acc_chain[k+1]),
                .acc_out (acc_chain[k])
            );
        end
    end

    // Round and clamp the completed sum held in the head of the chain.
    always_comb begin
        rs = round_sat(RS_W'(acc_chain[0]), SHIFT, OW);
    end

    assign unused_rs_hi = ^rs.value[RS_W-1:OW];
    assign unused_tap0  = ^tap_chain[0];

    // Marks the cycle in which acc_chain[0] holds a freshly completed sum.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ce_d <= 1'b0;
        end else begin
            ce_d <= i_ce;
        end
    end

    // Output register: strobe for one clock, hold result/flag between strobes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_ce       <= 1'b0;
            o_result   <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_ce <= ce_d;
            if (ce_d) begin
                o_result   <= rs.value[OW-1:0];
                o_overflow <= rs.clamped;
            end
        end
    end

endmodule
